// File: rtl/hypot_seq_ctrl.sv
// hypot_seq_ctrl: multi-cycle floor(sqrt(x^2+y^2)) sequencer.
// One shared adder/subtractor is time-multiplexed over three phases:
// shift-add square of x, shift-add square of y (accumulated on top of x^2),
// then a restoring digit-by-digit square root, MSB pair first.
module hypot_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   result,
  output logic         busy
);

  // Adder width covers the 2W+1-bit sum of squares and the W+3-bit
  // partial remainder of the root phase; the extra bit is carry/no-borrow.
  localparam int AW = 2*W + 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, SQX, SQY, SQRT, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   xr;
  logic [W-1:0]   yr;
  logic [2*W:0]   acc;
  logic [2*W+1:0] sum;
  logic [W:0]     rem;
  logic [W-1:0]   root;

  logic [W-1:0]   opnd;
  logic           op_bit;
  logic [W+2:0]   rem_shift;
  logic [AW-1:0]  add_a;
  logic [AW-1:0]  add_b;
  logic [AW-1:0]  add_b_eff;
  logic           sub;
  logic [AW:0]    add_res;
  logic           ge;
  logic [W:0]     root_nx;
  logic [W:0]     rem_nx;
  logic           last_sq;
  logic           last_rt;

  assign last_sq = (cnt == CW'(W - 1));
  assign last_rt = (cnt == CW'(W));

  // Shared adder: operand select per phase; subtract mode yields rem - trial
  // and its carry-out doubles as the rem >= trial comparison.
  always_comb begin
    add_a     = '0;
    add_b     = '0;
    sub       = 1'b0;
    opnd      = (state == SQY) ? yr : xr;
    op_bit    = |(opnd & (W'(1) << cnt));
    rem_shift = {rem, sum[2*W+1 -: 2]};
    case (state)
      SQX, SQY: begin
        add_a = AW'(acc);
        if (op_bit) add_b = AW'(opnd) << cnt;
      end
      SQRT: begin
        add_a = AW'(rem_shift);
        add_b = AW'({root, 2'b01});
        sub   = 1'b1;
      end
      default: ;
    endcase
    add_b_eff = sub ? ~add_b : add_b;
    add_res   = {1'b0, add_a} + {1'b0, add_b_eff} + {{AW{1'b0}}, sub};
    ge        = add_res[AW];
    if (ge) begin
      rem_nx  = add_res[W:0];
      root_nx = {root, 1'b1};
    end else begin
      rem_nx  = rem_shift[W:0];
      root_nx = {root, 1'b0};
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE) && ena && !rst;
    out_valid = (state == DONE);
    busy      = (state == SQX) || (state == SQY) || (state == SQRT);
    case (state)
      IDLE:    if (in_valid) state_nx = SQX;
      SQX:     if (last_sq) state_nx = SQY;
      SQY:     if (last_sq) state_nx = SQRT;
      SQRT:    if (last_rt) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and datapath; everything frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      xr     <= '0;
      yr     <= '0;
      acc    <= '0;
      sum    <= '0;
      rem    <= '0;
      root   <= '0;
      result <= '0;
    end else if (ena) begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr  <= x_in;
            yr  <= y_in;
            acc <= '0;
            cnt <= '0;
          end
        end
        SQX: begin
          acc <= add_res[2*W:0];
          cnt <= last_sq ? '0 : cnt + CW'(1);
        end
        SQY: begin
          acc <= add_res[2*W:0];
          if (last_sq) begin
            sum  <= {1'b0, add_res[2*W:0]};
            cnt  <= '0;
            rem  <= '0;
            root <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SQRT: begin
          sum  <= {sum[2*W-1:0], 2'b00};
          rem  <= rem_nx;
          root <= root_nx[W-1:0];
          if (last_rt) begin
            result <= root_nx;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_seq_ctrl.sv
// Directed bench for hypot_seq_ctrl: handshakes, latency, stalls, reset and a
// random sweep against an integer floor-sqrt model.
module tb_hypot_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] y_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W:0]   result;

  int tests = 0;
  int fails = 0;
  int in_hs = 0;
  int out_hs = 0;

  hypot_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && ena && in_valid && in_ready) in_hs <= in_hs + 1;
    if (!rst && ena && out_valid && out_ready) out_hs <= out_hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic start_op(input int x, input int y, input string tag);
    x_in = x[W-1:0];
    y_in = y[W-1:0];
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 300) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input int x, input int y, input int exp, input string tag);
    int e;
    out_ready = 1'b1;
    start_op(x, y, tag);
    wait_done(e);
    chk({tag, "_latency"}, e, 25);
    chk({tag, "_result"}, 32'(result), exp);
    tick();
    chk({tag, "_consumed"}, 32'(out_valid), 0);
  endtask

  initial begin
    int e;
    int base_in;
    int base_out;
    int x;
    int y;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // basic directed vectors
    run_op(3, 4, 5, "op_3_4");
    run_op(255, 255, 360, "op_255_255");
    run_op(0, 0, 0, "op_0_0");
    run_op(1, 1, 1, "op_1_1");

    // result held under back-pressure; in_valid during DONE not accepted
    out_ready = 1'b0;
    start_op(5, 12, "hold");
    wait_done(e);
    chk("hold_latency", e, 25);
    in_valid = 1'b1;
    x_in = 8'd1;
    y_in = 8'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_result", 32'(result), 13);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_consumed", 32'(out_valid), 0);
    chk("hold_idle_ready", 32'(in_ready), 1);

    // ena low for 5 cycles while squaring y
    start_op(8, 15, "ena");
    for (int i = 0; i < 10; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ena_low_in_ready", 32'(in_ready), 0);
      chk("ena_low_busy", 32'(busy), 1);
      chk("ena_low_out_valid", 32'(out_valid), 0);
    end
    ena = 1'b1;
    wait_done(e);
    chk("ena_latency", 15 + e, 30);
    chk("ena_result", 32'(result), 17);
    tick();
    chk("ena_consumed", 32'(out_valid), 0);

    // reset during the root phase
    start_op(200, 100, "rstmid");
    for (int i = 0; i < 20; i++) tick();
    chk("rstmid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("rstmid_in_ready_during", 32'(in_ready), 0);
    chk("rstmid_out_valid", 32'(out_valid), 0);
    chk("rstmid_result", 32'(result), 0);
    chk("rstmid_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    chk("rstmid_in_ready", 32'(in_ready), 1);
    run_op(6, 8, 10, "op_6_8");

    // random sweep with in_valid and operand noise while busy
    tick();
    base_in = in_hs;
    base_out = out_hs;
    out_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      case (n)
        0: begin x = 0;   y = 255; end
        1: begin x = 255; y = 0;   end
        2: begin x = 255; y = 255; end
        3: begin x = 0;   y = 0;   end
        4: begin x = 255; y = 1;   end
        default: begin
          x = int'($urandom_range(0, 255));
          y = int'($urandom_range(0, 255));
        end
      endcase
      start_op(x, y, "sweep");
      e = 0;
      while (!out_valid && e < 300) begin
        in_valid = 1'($urandom_range(0, 1));
        x_in = 8'($urandom_range(0, 255));
        y_in = 8'($urandom_range(0, 255));
        tick();
        e++;
      end
      in_valid = 1'b0;
      chk($sformatf("sweep_latency x=%0d y=%0d", x, y), e, 25);
      chk($sformatf("sweep_result x=%0d y=%0d", x, y), 32'(result), isqrt(x * x + y * y));
      tick();
    end
    tick();
    chk("sweep_in_handshakes", in_hs - base_in, 2000);
    chk("sweep_out_handshakes", out_hs - base_out, 2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
